// File: rtl/fpu_add_pipe_if.sv
// Handshake bundle for the pipelined FP adder.
//   master : operand issuer / result consumer (drives in_valid, a, b, sub, out_ready)
//   slave  : the adder (drives in_ready, out_valid, out and the exception flags)
interface fpu_add_pipe_if #(
  parameter int k = 64
) ();
  logic         in_valid;
  logic         in_ready;
  logic [k-1:0] a;
  logic [k-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [k-1:0] out;
  logic         overflow;
  logic         underflow;
  logic         inexact;
  logic         invalid;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, out, overflow, underflow, inexact, invalid
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, out, overflow, underflow, inexact, invalid
  );
endinterface

// File: rtl/fpu_add_pipe.sv
// 3-stage IEEE-754 adder/subtractor, round-to-nearest-even, flush-to-zero.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of fpu_add_pipe_if (operands + sub in, result + flags out,
//              valid/ready on both ends)
// Stage 1 unpacks, classifies, orders by magnitude and aligns; stage 2 adds and
// normalises; stage 3 rounds, packs and raises flags. The whole pipe advances
// together whenever the output slot is empty or being drained.
module fpu_add_pipe #(
  parameter int k = 64,
  parameter int w = 11,
  parameter int t = 52
) (
  input  logic          clk,
  input  logic          rst,
  fpu_add_pipe_if.slave bus
);
  localparam int STAGES = 3;
  localparam int EW     = w + 2;  // room for carry and rounding increments
  localparam int SMAX   = t + 3;  // alignment shift that leaves only sticky
  localparam logic [k-1:0]  QNAN = {1'b0, {w{1'b1}}, 1'b1, {(t-1){1'b0}}};
  localparam logic [EW-1:0] EMAX = {2'b00, {w{1'b1}}};

  logic              en;
  logic [STAGES:1]   vld_pipe_q;

  assign en           = !vld_pipe_q[STAGES] || bus.out_ready;
  assign bus.in_ready = en;

  // ---------------- stage 1: unpack / classify / align ----------------
  logic              sa, sb, za, zb, nan_a, nan_b, inf_a, inf_b, snan_a, snan_b;
  logic              eff_sub, inf_inv, swap, small_z;
  logic [w-1:0]      ea, eb, diff, shamt;
  logic [t-1:0]      fa, fb;
  logic [k-2:0]      mag_a, mag_b;
  logic [t:0]        sig_a, sig_b, sig_s;
  logic [2*t+5:0]    wide;
  logic              s1_spec_d, s1_inv_d, s1_sign_d;
  logic [k-1:0]      s1_res_d;
  logic [w-1:0]      s1_exp_d;
  logic [t+3:0]      s1_big_d, s1_small_d;

  logic              s1_spec_q, s1_inv_q, s1_sign_q, s1_sub_q;
  logic [k-1:0]      s1_res_q;
  logic [w-1:0]      s1_exp_q;
  logic [t+3:0]      s1_big_q, s1_small_q;

  always_comb begin
    sa      = bus.a[k-1];
    sb      = bus.b[k-1] ^ bus.sub;
    ea      = bus.a[k-2:t];
    eb      = bus.b[k-2:t];
    fa      = bus.a[t-1:0];
    fb      = bus.b[t-1:0];
    za      = (ea == '0);
    zb      = (eb == '0);
    nan_a   = (ea == '1) && (fa != '0);
    nan_b   = (eb == '1) && (fb != '0);
    inf_a   = (ea == '1) && (fa == '0);
    inf_b   = (eb == '1) && (fb == '0);
    snan_a  = nan_a && !fa[t-1];
    snan_b  = nan_b && !fb[t-1];
    eff_sub = sa ^ sb;
    inf_inv = inf_a && inf_b && eff_sub;

    s1_spec_d = nan_a || nan_b || inf_a || inf_b;
    s1_inv_d  = snan_a || snan_b || inf_inv;
    if (nan_a || nan_b || inf_inv) s1_res_d = QNAN;
    else if (inf_a)                s1_res_d = {sa, {w{1'b1}}, {t{1'b0}}};
    else                           s1_res_d = {sb, {w{1'b1}}, {t{1'b0}}};

    // Exponent-0 operands are zeros, so their magnitude and significand are forced to 0.
    mag_a   = za ? '0 : bus.a[k-2:0];
    mag_b   = zb ? '0 : bus.b[k-2:0];
    sig_a   = za ? '0 : {1'b1, fa};
    sig_b   = zb ? '0 : {1'b1, fb};
    swap    = (mag_b > mag_a);
    sig_s   = swap ? sig_a : sig_b;
    small_z = swap ? za : zb;
    diff    = swap ? (eb - ea) : (ea - eb);
    shamt   = (small_z || diff > w'(SMAX)) ? w'(SMAX) : diff;

    // Low half catches everything shifted past the round bit; it collapses to sticky.
    wide       = {sig_s, 2'b00, {(t+3){1'b0}}} >> shamt;
    s1_small_d = {wide[2*t+5:t+3], |wide[t+2:0]};
    s1_big_d   = {(swap ? sig_b : sig_a), 3'b000};
    s1_exp_d   = swap ? eb : ea;
    s1_sign_d  = swap ? sb : sa;
  end

  // ---------------- stage 2: add / normalise ----------------
  logic [t+4:0]      sum;
  logic [EW-1:0]     lz, e2;
  logic              s2_zero_d, s2_tiny_d, s2_sign_d;
  logic [EW-1:0]     s2_exp_d;
  logic [t+3:0]      s2_man_d;

  logic              s2_spec_q, s2_inv_q, s2_sign_q, s2_zero_q, s2_tiny_q;
  logic [k-1:0]      s2_res_q;
  logic [EW-1:0]     s2_exp_q;
  logic [t+3:0]      s2_man_q;

  always_comb begin
    // Operands are magnitude-ordered, so the difference never goes negative.
    sum = s1_sub_q ? ({1'b0, s1_big_q} - {1'b0, s1_small_q})
                   : ({1'b0, s1_big_q} + {1'b0, s1_small_q});
    lz = EW'(t + 4);
    for (int i = 0; i < t + 4; i++)
      if (sum[i]) lz = EW'(t + 3 - i);
    e2        = {2'b00, s1_exp_q};
    s2_zero_d = (sum == '0);
    s2_tiny_d = 1'b0;
    // A zero sum is +0 unless both inputs were zeros of the same sign.
    s2_sign_d = s2_zero_d ? (s1_sign_q & ~s1_sub_q) : s1_sign_q;
    if (sum[t+4]) begin
      s2_man_d = {sum[t+4:2], sum[1] | sum[0]};
      s2_exp_d = e2 + EW'(1);
    end else begin
      s2_man_d  = sum[t+3:0] << lz;
      s2_exp_d  = e2 - lz;
      s2_tiny_d = !s2_zero_d && (e2 <= lz);
    end
  end

  // ---------------- stage 3: round / pack / flags ----------------
  logic              inc, carry;
  logic [t+1:0]      rnd;
  logic [EW-1:0]     e3;
  logic [k-1:0]      out_d;
  logic [3:0]        flg_d;  // {overflow, underflow, inexact, invalid}

  logic [k-1:0]      out_q;
  logic [3:0]        flg_q;

  always_comb begin
    inc   = s2_man_q[2] & (s2_man_q[1] | s2_man_q[0] | s2_man_q[3]);
    rnd   = {1'b0, s2_man_q[t+3:3]} + {{(t+1){1'b0}}, inc};
    carry = rnd[t+1];
    e3    = s2_exp_q + {{(EW-1){1'b0}}, carry};
    out_d = {s2_sign_q, e3[w-1:0], (carry ? rnd[t:1] : rnd[t-1:0])};
    flg_d = {2'b00, |s2_man_q[2:0], 1'b0};
    if (s2_spec_q) begin
      out_d = s2_res_q;
      flg_d = {3'b000, s2_inv_q};
    end else if (s2_zero_q) begin
      out_d = {s2_sign_q, {(k-1){1'b0}}};
      flg_d = 4'b0000;
    end else if (s2_tiny_q) begin
      out_d = {s2_sign_q, {(k-1){1'b0}}};
      flg_d = 4'b0110;
    end else if (e3 >= EMAX) begin
      out_d = {s2_sign_q, {w{1'b1}}, {t{1'b0}}};
      flg_d = 4'b1010;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
      out_q      <= '0;
      flg_q      <= '0;
    end else if (en) begin
      vld_pipe_q <= {vld_pipe_q[STAGES-1:1], bus.in_valid};
      s1_spec_q  <= s1_spec_d;
      s1_inv_q   <= s1_inv_d;
      s1_res_q   <= s1_res_d;
      s1_sign_q  <= s1_sign_d;
      s1_sub_q   <= eff_sub;
      s1_exp_q   <= s1_exp_d;
      s1_big_q   <= s1_big_d;
      s1_small_q <= s1_small_d;
      s2_spec_q  <= s1_spec_q;
      s2_inv_q   <= s1_inv_q;
      s2_res_q   <= s1_res_q;
      s2_sign_q  <= s2_sign_d;
      s2_zero_q  <= s2_zero_d;
      s2_tiny_q  <= s2_tiny_d;
      s2_exp_q   <= s2_exp_d;
      s2_man_q   <= s2_man_d;
      out_q      <= out_d;
      flg_q      <= flg_d;
    end
  end

  assign bus.out_valid = vld_pipe_q[STAGES];
  assign bus.out       = out_q;
  assign bus.overflow  = flg_q[3] & vld_pipe_q[STAGES];
  assign bus.underflow = flg_q[2] & vld_pipe_q[STAGES];
  assign bus.inexact   = flg_q[1] & vld_pipe_q[STAGES];
  assign bus.invalid   = flg_q[0] & vld_pipe_q[STAGES];
endmodule

// File: tb/tb_fpu_add_pipe.sv
module tb_fpu_add_pipe;
  localparam logic [31:0] QNAN = 32'h7FC00000;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [35:0] e;  // {result, overflow, underflow, inexact, invalid}
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fpu_add_pipe_if #(.k(32)) bus ();
  fpu_add_pipe #(.k(32), .w(8), .t(23)) dut (.clk(clk), .rst(rst), .bus(bus));

  int   n_cmp = 0;
  int   n_bad = 0;
  bit   rnd_rdy = 1'b0;
  exp_t exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
    n_cmp++;
    if (obs !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, req);
    end
  endtask

  // IEEE single -> real, exponent-0 values become signed zero.
  function automatic real f2r(input logic s, input logic [7:0] e, input logic [22:0] f);
    logic [10:0] be;
    be = 11'(int'(e) + 896);
    if (e == 8'd0) return $bitstoreal({s, 63'd0});
    return $bitstoreal({s, be, f, 29'd0});
  endfunction

  // Reference: specials by rule, finite sums in double precision (exact error via
  // TwoSum), then rounded to single with RNE and flush/overflow rules.
  function automatic logic [35:0] model(input logic [31:0] x, input logic [31:0] y, input logic s);
    logic        sx, sy, nx, ny, ix, iy, up, inx;
    logic [63:0] d;
    logic [28:0] rem;
    logic [24:0] m;
    real         rx, ry, r, bb, err;
    int          ee, fe;
    logic [31:0] fev;
    sx = x[31];
    sy = y[31] ^ s;
    nx = (x[30:23] == 8'hFF) && (x[22:0] != 0);
    ny = (y[30:23] == 8'hFF) && (y[22:0] != 0);
    ix = (x[30:23] == 8'hFF) && (x[22:0] == 0);
    iy = (y[30:23] == 8'hFF) && (y[22:0] == 0);
    if (nx || ny) return {QNAN, 3'b000, (nx && !x[22]) || (ny && !y[22])};
    if (ix && iy && sx != sy) return {QNAN, 4'b0001};
    if (ix) return {sx, 8'hFF, 23'd0, 4'b0000};
    if (iy) return {sy, 8'hFF, 23'd0, 4'b0000};
    rx  = f2r(sx, x[30:23], x[22:0]);
    ry  = f2r(sy, y[30:23], y[22:0]);
    r   = rx + ry;
    bb  = r - rx;
    err = (rx - (r - bb)) + (ry - bb);
    d   = $realtobits(r);
    if (r == 0.0) return {d[63], 31'd0, 4'b0000};
    ee = int'(d[62:52]) - 1023;
    if (ee < -126) return {d[63], 31'd0, 4'b0110};
    rem = d[28:0];
    up  = (rem > 29'h1000_0000) || (rem == 29'h1000_0000 && d[29]);
    m   = {2'b01, d[51:29]} + {24'd0, up};
    fe  = ee + 127;
    if (m[24]) begin
      fe = fe + 1;
      m  = m >> 1;
    end
    if (fe >= 255) return {d[63], 8'hFF, 23'd0, 4'b1010};
    inx = (rem != 0) || (err != 0.0);
    fev = 32'(fe);
    return {d[63], fev[7:0], m[22:0], 2'b00, inx, 1'b0};
  endfunction

  function automatic logic [31:0] rnd_op(input logic [31:0] other, input bit near);
    int          kind;
    logic [31:0] v;
    kind = $urandom_range(0, 15);
    v    = $urandom;
    if (near && kind >= 6 && kind <= 9) begin
      // close to the other operand: exercises cancellation and tie rounding
      v = {v[31], other[30:8], v[7:0]};
      if (kind == 9) v[30:23] = other[30:23] + 8'd1;
    end else begin
      case (kind)
        0: v[30:0] = 31'd0;
        1: v[30:0] = {8'hFF, 23'd0};
        2: begin v[30:23] = 8'hFF; v[0] = 1'b1; end
        3: v[30:23] = 8'h00;
        4: v[30:23] = 8'($urandom_range(250, 254));
        5: v[30:23] = 8'($urandom_range(1, 6));
        default: v[30:23] = 8'($urandom_range(100, 154));
      endcase
    end
    return v;
  endfunction

  // Advance to just after the next rising edge; optionally re-roll out_ready.
  task automatic step();
    @(posedge clk);
    #1;
    if (rnd_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Present one operand pair until accepted; call just after a rising edge.
  task automatic issue(input logic [31:0] xa, input logic [31:0] xb, input logic xs,
                       input logic [35:0] e);
    int   n;
    bit   acc;
    exp_t it;
    n   = 0;
    acc = 1'b0;
    bus.in_valid = 1'b1;
    bus.a        = xa;
    bus.b        = xb;
    bus.sub      = xs;
    while (!acc && n < 60) begin
      @(negedge clk);
      if (bus.in_ready) acc = 1'b1;
      else begin
        n++;
        step();
      end
    end
    if (acc) begin
      it.a = xa; it.b = xb; it.s = xs; it.e = e;
      exp_q.push_back(it);
    end else chk("issue_timeout", 64'(bus.in_ready), 64'd1);
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_lat(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.out_valid && n < 20);
    chk(tag, 64'(n), 64'd3);
  endtask

  task automatic drain(input string tag, input int lim);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(exp_q.size()), 64'd0);
    step();
  endtask

  // Scoreboard: every transfer must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t it;
    if (!rst) begin
      if (bus.out_valid && bus.out_ready) begin
        chk("sb_pending", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          it = exp_q.pop_front();
          chk($sformatf("res %h%s%h", it.a, (it.s ? "-" : "+"), it.b),
              {28'd0, bus.out, bus.overflow, bus.underflow, bus.inexact, bus.invalid},
              {28'd0, it.e});
        end
      end else if (!bus.out_valid) begin
        chk("flags_idle", 64'({bus.overflow, bus.underflow, bus.inexact, bus.invalid}), 64'd0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] ra, rb, held;
    logic        rs;
    logic [31:0] da[11];
    logic [31:0] db[11];
    logic        ds[11];
    logic [35:0] de[11];
    da = '{32'h3F800000, 32'h3F800000, 32'h80000000, 32'h7F7FFFFF, 32'h3F800000, 32'h3F800001,
           32'h7F800000, 32'h7FA00000, 32'h00800001, 32'h40490FDB, 32'hFF800000};
    db = '{32'h40000000, 32'h3F800000, 32'h80000000, 32'h7F7FFFFF, 32'h33800000, 32'h33800000,
           32'h7F800000, 32'h3F800000, 32'h00800000, 32'h80000000, 32'h3F800000};
    ds = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    de = '{{32'h40400000, 4'b0000}, {32'h00000000, 4'b0000}, {32'h80000000, 4'b0000},
           {32'h7F800000, 4'b1010}, {32'h3F800000, 4'b0010}, {32'h3F800002, 4'b0010},
           {32'h7FC00000, 4'b0001}, {32'h7FC00000, 4'b0001}, {32'h00000000, 4'b0110},
           {32'h40490FDB, 4'b0000}, {32'hFF800000, 4'b0000}};

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b1;
    rst           = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out", 64'(bus.out), 64'd0);
    chk("rst_flags", 64'({bus.overflow, bus.underflow, bus.inexact, bus.invalid}), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    step();

    // directed vectors, one at a time, each with a latency check
    for (int i = 0; i < 11; i++) begin
      issue(da[i], db[i], ds[i], de[i]);
      wait_lat($sformatf("latency_%0d", i));
      drain("drain_dir", 20);
    end

    // four back-to-back, then hold the output for five cycles
    for (int i = 0; i < 4; i++) begin
      ra = rnd_op(32'd0, 1'b0);
      rb = rnd_op(ra, 1'b1);
      issue(ra, rb, 1'b0, model(ra, rb, 1'b0));
    end
    bus.out_ready = 1'b0;
    @(negedge clk);
    held = bus.out;
    chk("stall_valid", 64'(bus.out_valid), 64'd1);
    chk("stall_front", 64'(bus.out), 64'(exp_q[0].e[35:4]));
    repeat (5) begin
      @(negedge clk);
      chk("stall_hold", 64'(bus.out), 64'(held));
      chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
    end
    step();
    bus.out_ready = 1'b1;
    drain("drain_stall", 30);

    // reset with operations in flight: nothing may come out afterwards
    for (int i = 0; i < 2; i++) begin
      ra = rnd_op(32'd0, 1'b0);
      issue(ra, 32'h3F800000, 1'b0, model(ra, 32'h3F800000, 1'b0));
    end
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_valid", 64'(bus.out_valid), 64'd0);
    step();
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("post_rst_idle", 64'(bus.out_valid), 64'd0);
    end
    step();

    // randomized traffic with random back-pressure and idle gaps
    rnd_rdy = 1'b1;
    for (int i = 0; i < 400; i++) begin
      ra = rnd_op(32'd0, 1'b0);
      rb = rnd_op(ra, 1'b1);
      rs = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 4) == 0) step();
      issue(ra, rb, rs, model(ra, rb, rs));
    end
    rnd_rdy = 1'b0;
    bus.out_ready = 1'b1;
    drain("drain_rand", 200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
